// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and helpers for the pending-interrupt encoder
package irq_pkg;

   localparam int NUM_BITS_DEFAULT = 3;
   // Helpers are sized for the widest supported encoder; callers cast in and out.
   localparam int MAX_BITS = 8;
   localparam int MAX_N    = 1 << MAX_BITS;

   function automatic logic [MAX_N-1:0] onehot(input logic [MAX_BITS-1:0] idx);
      logic [MAX_N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [MAX_BITS:0] popcount(input logic [MAX_N-1:0] vec);
      logic [MAX_BITS:0] c;
      c = '0;
      for (int i = 0; i < MAX_N; i++) begin
         c = c + (MAX_BITS+1)'(vec[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// rtl/prio_enc_comb.sv - combinational 2^n-to-n encoder, highest set index wins
module prio_enc_comb #(
   parameter int NUM_BITS = 3
) (
   input  logic [2**NUM_BITS-1:0] vec,
   output logic [NUM_BITS-1:0]    idx,
   output logic                   any
);

   always_comb begin
      idx = '0;
      any = |vec;
      // Ascending scan so the last hit, the highest index, is the one kept.
      for (int i = 0; i < 2**NUM_BITS; i++) begin
         if (vec[i]) begin
            idx = NUM_BITS'(i);
         end
      end
   end

endmodule

// File: rtl/irq_pending_encoder.sv
// rtl/irq_pending_encoder.sv - sticky pending register, mask and valid/ready index presentation
module irq_pending_encoder
   import irq_pkg::*;
#(
   parameter int NUM_BITS = NUM_BITS_DEFAULT,
   parameter int CNT_W    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2**NUM_BITS-1:0] req,
   input  logic [2**NUM_BITS-1:0] mask,
   input  logic                   ready,
   output logic                   valid,
   output logic [NUM_BITS-1:0]    index,
   output logic [2**NUM_BITS-1:0] pending,
   output logic [CNT_W-1:0]       drop_cnt
);

   localparam int N     = 2**NUM_BITS;
   localparam int SUM_W = CNT_W + MAX_BITS + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             accept;
   logic             load;
   logic [N-1:0]     clr_vec;
   logic [N-1:0]     pending_next;
   logic [N-1:0]     drop_vec;
   logic [N-1:0]     eligible;
   logic [NUM_BITS-1:0] enc_idx;
   logic             enc_any;
   logic [SUM_W-1:0] cnt_sum;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      accept       = valid & ready;
      clr_vec      = accept ? N'(onehot(MAX_BITS'(index))) : '0;
      pending_next = (pending & ~clr_vec) | req;
      // A request landing on the bit being cleared re-arms it rather than dropping.
      drop_vec     = req & pending & ~clr_vec;
      eligible     = pending & ~mask & ~clr_vec;
      load         = !valid || accept;
      cnt_sum      = SUM_W'(drop_cnt) + SUM_W'(popcount(MAX_N'(drop_vec)));
      cnt_next     = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
   end

   prio_enc_comb #(
      .NUM_BITS (NUM_BITS)
   ) u_enc (
      .vec (eligible),
      .idx (enc_idx),
      .any (enc_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pending  <= '0;
         valid    <= 1'b0;
         index    <= '0;
         drop_cnt <= '0;
      end else begin
         pending  <= pending_next;
         drop_cnt <= cnt_next;
         // Presented index is frozen until accepted: no preemption, no retraction.
         if (load) begin
            valid <= enc_any;
            index <= enc_idx;
         end
      end
   end

endmodule
